// File: rtl/processing_unit_node_pkg.sv
// Shared decoder constants: stage codes used by the vertex nodes and the link channels.
package processing_unit_node_pkg;

   localparam int STAGE_WIDTH = 3;

   localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
   localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
   localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
   localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;

   // True on the first cycle the controller presents `target` after presenting something else.
   function automatic logic stage_entered(input logic [STAGE_WIDTH-1:0] cur,
                                          input logic [STAGE_WIDTH-1:0] prev,
                                          input logic [STAGE_WIDTH-1:0] target);
      return (cur == target) && (prev != target);
   endfunction

endpackage

// File: rtl/processing_unit_node_min_root_select.sv
// Combinational log-depth minimum finder over the masked neighbour roots; ties go to the lowest index.
module min_root_select #(
   parameter int ADDRESS_WIDTH  = 6,
   parameter int NEIGHBOR_COUNT = 6
) (
   input  logic [NEIGHBOR_COUNT-1:0]               candidate,
   input  logic [NEIGHBOR_COUNT*ADDRESS_WIDTH-1:0] roots,
   output logic [ADDRESS_WIDTH-1:0]                min_root,
   output logic [NEIGHBOR_COUNT-1:0]               min_index,
   output logic                                    valid
);

   localparam int LVL = (NEIGHBOR_COUNT > 1) ? $clog2(NEIGHBOR_COUNT) : 0;
   localparam int PAD = 1 << LVL;

   logic [ADDRESS_WIDTH-1:0]  lvl_root [LVL+1][PAD];
   logic [NEIGHBOR_COUNT-1:0] lvl_idx  [LVL+1][PAD];
   logic                      lvl_vld  [LVL+1][PAD];
   logic                      take_left;

   always_comb begin
      take_left = 1'b0;
      for (int l = 0; l <= LVL; l++) begin
         for (int p = 0; p < PAD; p++) begin
            lvl_root[l][p] = '0;
            lvl_idx[l][p]  = '0;
            lvl_vld[l][p]  = 1'b0;
         end
      end
      for (int p = 0; p < NEIGHBOR_COUNT; p++) begin
         lvl_root[0][p]    = roots[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
         lvl_idx[0][p][p]  = 1'b1;
         lvl_vld[0][p]     = candidate[p];
      end
      // The left operand always holds the lower indices, so preferring it on equality breaks ties low.
      for (int l = 0; l < LVL; l++) begin
         for (int p = 0; p < (PAD >> (l + 1)); p++) begin
            take_left = lvl_vld[l][2*p] &&
                        (!lvl_vld[l][2*p+1] || (lvl_root[l][2*p] <= lvl_root[l][2*p+1]));
            lvl_root[l+1][p] = take_left ? lvl_root[l][2*p] : lvl_root[l][2*p+1];
            lvl_idx[l+1][p]  = take_left ? lvl_idx[l][2*p]  : lvl_idx[l][2*p+1];
            lvl_vld[l+1][p]  = lvl_vld[l][2*p] | lvl_vld[l][2*p+1];
         end
      end
   end

   assign min_root  = lvl_root[LVL][0];
   assign min_index = lvl_vld[LVL][0] ? lvl_idx[LVL][0] : '0;
   assign valid     = lvl_vld[LVL][0];

endmodule

// File: rtl/processing_unit_node.sv
// Union-find vertex node: loads a syndrome bit, pulses growth once per GROW entry, adopts the minimum
// root over fully grown links during MERGE. Optional boundary tracking is enabled by PU_BOUNDARY_EN.
module processing_unit_node
   import processing_unit_node_pkg::*;
#(
   parameter int ADDRESS        = 0,
   parameter int ADDRESS_WIDTH  = 6,
   parameter int NEIGHBOR_COUNT = 6
) (
   input  logic                                    clk,
   input  logic                                    reset_n,
   input  logic [STAGE_WIDTH-1:0]                  global_stage,
   input  logic                                    measurement_in,
   input  logic [NEIGHBOR_COUNT-1:0]               fully_grown,
   input  logic [NEIGHBOR_COUNT-1:0]               is_boundary,
   input  logic [NEIGHBOR_COUNT*ADDRESS_WIDTH-1:0] neighbor_root_in,
   output logic [ADDRESS_WIDTH-1:0]                root,
   output logic [NEIGHBOR_COUNT-1:0]               parent_vector,
   output logic                                    increase,
   output logic                                    odd,
   output logic                                    touching_boundary,
   output logic                                    busy
);

   localparam logic [ADDRESS_WIDTH-1:0] ROOT_INIT = ADDRESS_WIDTH'(ADDRESS);

   logic [ADDRESS_WIDTH-1:0]  root_q,   root_d;
   logic [NEIGHBOR_COUNT-1:0] parent_q, parent_d;
   logic                      odd_q,    odd_d;
   logic                      touch_q,  touch_d;
   logic                      busy_q,   busy_d;
   logic                      incr_q,   incr_d;
   logic [STAGE_WIDTH-1:0]    stage_q;

   logic [ADDRESS_WIDTH-1:0]  min_root;
   logic [NEIGHBOR_COUNT-1:0] min_index;
   logic                      min_valid;
   logic                      grow_entry;

   min_root_select #(
      .ADDRESS_WIDTH  (ADDRESS_WIDTH),
      .NEIGHBOR_COUNT (NEIGHBOR_COUNT)
   ) u_min_root_select (
      .candidate (fully_grown),
      .roots     (neighbor_root_in),
      .min_root  (min_root),
      .min_index (min_index),
      .valid     (min_valid)
   );

   assign grow_entry = stage_entered(global_stage, stage_q, STAGE_GROW);

`ifndef PU_BOUNDARY_EN
   logic unused_boundary;
   assign unused_boundary = ^is_boundary;
`endif

   always_comb begin
      root_d   = root_q;
      parent_d = parent_q;
      odd_d    = odd_q;
      touch_d  = touch_q;
      busy_d   = 1'b0;
      incr_d   = 1'b0;
      case (global_stage)
         STAGE_MEASUREMENT_LOADING: begin
            root_d   = ROOT_INIT;
            parent_d = '0;
            odd_d    = measurement_in;
            touch_d  = 1'b0;
         end
         // Links integrate `increase` every cycle, so it may only be high on the entry cycle.
         STAGE_GROW: incr_d = grow_entry & odd_q & ~touch_q;
         STAGE_MERGE: begin
            if (min_valid && (min_root < root_q)) begin
               root_d   = min_root;
               parent_d = min_index;
               busy_d   = 1'b1;
            end
`ifdef PU_BOUNDARY_EN
            touch_d = touch_q | (|is_boundary);
`endif
         end
         default: ;
      endcase
`ifndef PU_BOUNDARY_EN
      touch_d = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         root_q   <= ROOT_INIT;
         parent_q <= '0;
         odd_q    <= 1'b0;
         touch_q  <= 1'b0;
         busy_q   <= 1'b0;
         incr_q   <= 1'b0;
         stage_q  <= STAGE_IDLE;
      end else begin
         root_q   <= root_d;
         parent_q <= parent_d;
         odd_q    <= odd_d;
         touch_q  <= touch_d;
         busy_q   <= busy_d;
         incr_q   <= incr_d;
         stage_q  <= global_stage;
      end
   end

   assign root              = root_q;
   assign parent_vector     = parent_q;
   assign increase          = incr_q;
   assign odd               = odd_q;
   assign touching_boundary = touch_q;
   assign busy              = busy_q;

endmodule

// File: tb/tb_processing_unit_node.sv
// Directed scoreboard bench for processing_unit_node: single node (ADDRESS=5) plus a three-node chain.
module tb_processing_unit_node;
   import processing_unit_node_pkg::*;

`ifdef PU_BOUNDARY_EN
   localparam logic BEN = 1'b1;
`else
   localparam logic BEN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [STAGE_WIDTH-1:0] stage = STAGE_IDLE;
   logic        meas = 1'b0;
   logic [5:0]  fg = '0;
   logic [5:0]  ib = '0;
   logic [35:0] nroots = '1;
   logic [5:0]  root, pv;
   logic        inc, odd, tb, busy;

   processing_unit_node #(.ADDRESS(5), .ADDRESS_WIDTH(6), .NEIGHBOR_COUNT(6)) dut (
      .clk (clk), .reset_n (reset_n), .global_stage (stage), .measurement_in (meas),
      .fully_grown (fg), .is_boundary (ib), .neighbor_root_in (nroots),
      .root (root), .parent_vector (pv), .increase (inc), .odd (odd),
      .touching_boundary (tb), .busy (busy)
   );

   // Chain A(1) - B(4) - C(9), every real link fully grown.
   logic [STAGE_WIDTH-1:0] cstage = STAGE_IDLE;
   logic [5:0] a_root, b_root, c_root;
   logic [1:0] a_pv, b_pv, c_pv;
   logic       a_inc, b_inc, c_inc, a_odd, b_odd, c_odd, a_tb, b_tb, c_tb, a_busy, b_busy, c_busy;
   logic [11:0] a_nr, b_nr, c_nr;
   assign a_nr = {6'h3F, b_root};
   assign b_nr = {c_root, a_root};
   assign c_nr = {6'h3F, b_root};

   processing_unit_node #(.ADDRESS(1), .ADDRESS_WIDTH(6), .NEIGHBOR_COUNT(2)) node_a (
      .clk (clk), .reset_n (reset_n), .global_stage (cstage), .measurement_in (1'b0),
      .fully_grown (2'b01), .is_boundary (2'b00), .neighbor_root_in (a_nr),
      .root (a_root), .parent_vector (a_pv), .increase (a_inc), .odd (a_odd),
      .touching_boundary (a_tb), .busy (a_busy)
   );
   processing_unit_node #(.ADDRESS(4), .ADDRESS_WIDTH(6), .NEIGHBOR_COUNT(2)) node_b (
      .clk (clk), .reset_n (reset_n), .global_stage (cstage), .measurement_in (1'b0),
      .fully_grown (2'b11), .is_boundary (2'b00), .neighbor_root_in (b_nr),
      .root (b_root), .parent_vector (b_pv), .increase (b_inc), .odd (b_odd),
      .touching_boundary (b_tb), .busy (b_busy)
   );
   processing_unit_node #(.ADDRESS(9), .ADDRESS_WIDTH(6), .NEIGHBOR_COUNT(2)) node_c (
      .clk (clk), .reset_n (reset_n), .global_stage (cstage), .measurement_in (1'b0),
      .fully_grown (2'b01), .is_boundary (2'b00), .neighbor_root_in (c_nr),
      .root (c_root), .parent_vector (c_pv), .increase (c_inc), .odd (c_odd),
      .touching_boundary (c_tb), .busy (c_busy)
   );

   typedef struct packed {
      logic [5:0] root;
      logic [5:0] pv;
      logic       inc;
      logic       odd;
      logic       tb;
      logic       busy;
   } exp_t;

   exp_t  sb[$];
   string tags[$];
   int    n_total = 0;
   int    n_pass  = 0;

   task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic expect_out(input string tag, input logic [5:0] e_root, input logic [5:0] e_pv,
                             input logic e_inc, input logic e_odd, input logic e_tb, input logic e_busy);
      exp_t e;
      e.root = e_root; e.pv = e_pv; e.inc = e_inc; e.odd = e_odd; e.tb = e_tb; e.busy = e_busy;
      sb.push_back(e);
      tags.push_back(tag);
   endtask

   task automatic pop_check();
      exp_t  e;
      string t;
      if (sb.size() == 0) begin
         n_total++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = sb.pop_front();
      t = tags.pop_front();
      chk({t, ".root"}, root, e.root);
      chk({t, ".parent"}, pv, e.pv);
      chk({t, ".increase"}, 6'(inc), 6'(e.inc));
      chk({t, ".odd"}, 6'(odd), 6'(e.odd));
      chk({t, ".touch"}, 6'(tb), 6'(e.tb));
      chk({t, ".busy"}, 6'(busy), 6'(e.busy));
   endtask

   task automatic step(input string tag, input logic [STAGE_WIDTH-1:0] st,
                       input logic [5:0] e_root, input logic [5:0] e_pv,
                       input logic e_inc, input logic e_odd, input logic e_tb, input logic e_busy);
      stage = st;
      expect_out(tag, e_root, e_pv, e_inc, e_odd, e_tb, e_busy);
      @(posedge clk);
      #1;
      pop_check();
   endtask

   task automatic set_root(input int i, input logic [5:0] v);
      nroots[i*6 +: 6] = v;
   endtask

   task automatic cstep(input string tag, input logic [STAGE_WIDTH-1:0] st,
                        input logic [5:0] e_b, input logic e_bb,
                        input logic [5:0] e_c, input logic e_cb, input logic [1:0] e_cpv);
      cstage = st;
      @(posedge clk);
      #1;
      chk({tag, ".a_root"}, a_root, 6'd1);
      chk({tag, ".b_root"}, b_root, e_b);
      chk({tag, ".b_busy"}, 6'(b_busy), 6'(e_bb));
      chk({tag, ".c_root"}, c_root, e_c);
      chk({tag, ".c_busy"}, 6'(c_busy), 6'(e_cb));
      chk({tag, ".c_parent"}, 6'(c_pv), 6'(e_cpv));
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      expect_out("reset", 6'd5, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      pop_check();
      chk("reset.c_root", c_root, 6'd9);
      #2 reset_n = 1'b1;

      meas = 1'b1;
      step("load1",   STAGE_MEASUREMENT_LOADING, 6'd5, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      meas = 1'b0;
      step("grow_e",  STAGE_GROW, 6'd5, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      step("grow_2",  STAGE_GROW, 6'd5, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("grow_3",  STAGE_GROW, 6'd5, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("grow_4",  STAGE_GROW, 6'd5, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      fg = 6'b000110;
      set_root(0, 6'd1);
      set_root(1, 6'd3);
      set_root(2, 6'd3);
      step("merge_tie12", STAGE_MERGE, 6'd3, 6'b000010, 1'b0, 1'b1, 1'b0, 1'b1);
      ib = 6'b000001;
      step("merge_hold",  STAGE_MERGE, 6'd3, 6'b000010, 1'b0, 1'b1, BEN, 1'b0);
      ib = 6'b000000;
      step("idle",        STAGE_IDLE,  6'd3, 6'b000010, 1'b0, 1'b1, BEN, 1'b0);
      step("regrow",      STAGE_GROW,  6'd3, 6'b000010, ~BEN, 1'b1, BEN, 1'b0);
      step("regrow_2",    STAGE_GROW,  6'd3, 6'b000010, 1'b0, 1'b1, BEN, 1'b0);

      step("load0",       STAGE_MEASUREMENT_LOADING, 6'd5, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      fg = 6'b000001;
      set_root(0, 6'd7);
      step("merge_above", STAGE_MERGE, 6'd5, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      fg = 6'b100000;
      set_root(5, 6'd2);
      step("merge_link5", STAGE_MERGE, 6'd2, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b1);

      #3 reset_n = 1'b0;
      #1;
      expect_out("async_rst", 6'd5, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      pop_check();
      @(posedge clk);
      #2 reset_n = 1'b1;

      meas = 1'b1;
      step("load_t",      STAGE_MEASUREMENT_LOADING, 6'd5, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      fg = 6'b110000;
      set_root(4, 6'd1);
      set_root(5, 6'd1);
      step("merge_tie45", STAGE_MERGE, 6'd1, 6'b010000, 1'b0, 1'b1, 1'b0, 1'b1);
      step("unknown",     3'b111,      6'd1, 6'b010000, 1'b0, 1'b1, 1'b0, 1'b0);
      step("merge_conv",  STAGE_MERGE, 6'd1, 6'b010000, 1'b0, 1'b1, 1'b0, 1'b0);
      step("grow_again",  STAGE_GROW,  6'd1, 6'b010000, 1'b1, 1'b1, 1'b0, 1'b0);
      step("grow_again2", STAGE_GROW,  6'd1, 6'b010000, 1'b0, 1'b1, 1'b0, 1'b0);
      stage = STAGE_IDLE;

      cstep("chain_load", STAGE_MEASUREMENT_LOADING, 6'd4, 1'b0, 6'd9, 1'b0, 2'b00);
      cstep("chain_m1",   STAGE_MERGE, 6'd1, 1'b1, 6'd4, 1'b1, 2'b01);
      cstep("chain_m2",   STAGE_MERGE, 6'd1, 1'b0, 6'd1, 1'b1, 2'b01);
      cstep("chain_m3",   STAGE_MERGE, 6'd1, 1'b0, 6'd1, 1'b0, 2'b01);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/processing_unit_node.md
# processing_unit_node

Per-vertex decoding node that drives and consumes the neighbour link channels in the union-find decoder array. Each instance holds one syndrome measurement, issues single-cycle growth increments to its links during the grow stage, and propagates the minimum cluster root through fully grown links during the merge stage. It records a one-hot parent vector toward the neighbour that supplied its root, and flags boundary contact. A global `busy` reduction across all nodes tells the controller when merging has converged.

## Interface
Parameters:
- `ADDRESS`, 0: this node's unique root ID; the reset and load value of `root`.
- `ADDRESS_WIDTH`, 6: width of root IDs.
- `NEIGHBOR_COUNT`, 6: number of attached links; at least 1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `global_stage`  in  STAGE_WIDTH  decoder stage from the controller.
- `measurement_in`  in  1  syndrome bit; sampled in STAGE_MEASUREMENT_LOADING.
- `fully_grown`  in  NEIGHBOR_COUNT  per-link fully grown flag.
- `is_boundary`  in  NEIGHBOR_COUNT  per-link boundary-reached flag.
- `neighbor_root_in`  in  NEIGHBOR_COUNT*ADDRESS_WIDTH  root of each neighbour; link i occupies bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- `root`  out  ADDRESS_WIDTH  current cluster root; fanned out to every link.
- `parent_vector`  out  NEIGHBOR_COUNT  one-hot toward the parent; all zero when `root == ADDRESS`.
- `increase`  out  1  growth pulse to every link.
- `odd`  out  1  registered measurement bit.
- `touching_boundary`  out  1  node has reached a boundary.
- `busy`  out  1  `root` changed in the previous cycle.

## Operation
Reset (asynchronous, `reset_n` low) sets:
- `root = ADDRESS`
- all other outputs and internal state to 0, including the stage-edge register.

STAGE_MEASUREMENT_LOADING, every cycle:
- `root <= ADDRESS`, `parent_vector <= 0`, `odd <= measurement_in`, `touching_boundary <= 0`, `busy <= 0`.

STAGE_GROW:
- `increase` is a registered single-cycle pulse, asserted only on the first cycle after `global_stage` changes to STAGE_GROW.
- Its value is `odd & ~touching_boundary`.
- It stays 0 for the rest of the stage. Links accumulate `increase` every cycle, so it must never be held high.

STAGE_MERGE, every cycle:
- Candidates are the links i with `fully_grown[i]`.
- Select the minimum `neighbor_root_in` among candidates. Ties go to the lowest index.
- If that minimum is below `root`: `root <= min`, `parent_vector <= onehot(i)`, `busy <= 1`.
- Otherwise `root` and `parent_vector` hold and `busy <= 0`.
- With no candidates: `busy <= 0`.

Any other stage (STAGE_IDLE, unknown codes):
- All state holds; `busy <= 0`; `increase <= 0`.

Comparison is unsigned over ADDRESS_WIDTH bits, with no wrap.

## Timing
- `increase`: one cycle after STAGE_GROW is entered, high for exactly one cycle per entry. Re-entering GROW after another stage produces a new pulse.
- Root propagation: one cycle per hop. A root k hops away arrives after k merge cycles.
- `busy`: asserted in the cycle after the `root` update, for one cycle per change.
- Stage change mid-merge: the update from the last MERGE cycle completes; later cycles follow the new stage.
- `reset_n` deassertion mid-stage: the node restarts from reset values. The stage-edge register is 0, so a pulse fires if the stage is GROW.

## Configuration
- `PU_BOUNDARY_EN` defined:
  - In STAGE_MERGE, `touching_boundary <= touching_boundary | (|is_boundary)`. It is sticky until the next measurement load.
  - `touching_boundary` suppresses `increase`.
- `PU_BOUNDARY_EN` undefined:
  - `is_boundary` is ignored and `touching_boundary` is tied to 0.
  - `increase = odd` on the pulse cycle.

## Structure
- Stage codes (`STAGE_WIDTH`, `STAGE_IDLE`, `STAGE_MEASUREMENT_LOADING`, `STAGE_GROW`, `STAGE_MERGE`) belong in the shared parameters package, alongside the link channels' stage constants.
- Sub-module `min_root_select`:
  - Combinational log-depth comparator tree over NEIGHBOR_COUNT masked roots.
  - Outputs `min_root`, the one-hot `min_index`, and `valid`.
  - Ties resolve to the lowest index.

## Test plan
- Load with `measurement_in=1`, ADDRESS=5, then GROW for 4 cycles: `increase` is 1 for exactly one cycle, the cycle after GROW entry; `root` stays 5.
- MERGE with `fully_grown=6'b000110`, roots link1=3, link2=3, ADDRESS=5: next cycle `root=3`, `parent_vector=6'b000010`, `busy=1`; following cycle `busy=0`.
- MERGE with a candidate root 7 > ADDRESS=5: `root` stays 5, `parent_vector=0`, `busy` stays 0.
- `PU_BOUNDARY_EN` set, `is_boundary[0]=1` during MERGE, then GROW re-entered with `odd=1`: `touching_boundary=1` and no `increase` pulse. With the macro unset, the pulse occurs.
- Assert `reset_n=0` asynchronously mid-MERGE after `root=2`: outputs drop immediately to `root=ADDRESS`, all others 0.
- Three-node chain with roots 1, 4, 9, all links grown: node 9 reaches root 1 after 2 merge cycles, with `busy` high in each update cycle.
